serial_add_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that time-multiplexes a single full-adder cell over an N-bit operand pair, LSB first, one bit per clock. It sits in the FPU datapath as the low-area alternative to a parallel ripple adder for mantissa add/sub. It latches operands on a START handshake, runs N bit-steps, then reports sum, carry-out and signed overflow with a one-cycle DONE pulse. Results hold until the next completed operation.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/serial_add_ctrl_fa.sv | 16 +
 rtl/serial_add_ctrl.sv | 151 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions: controller state encoding and counter sizing.
package fpu_pkg;

  // Sequencer states; encodings are fixed so existing decode logic keeps working.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  // Supported operand widths for the bit-serial adder.
  localparam int unsigned N_MIN = 2;
  localparam int unsigned N_MAX = 64;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell shared by the bit-serial add/subtract sequencer.
module FA (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of one bit position.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one FA cell walks an N-bit operand pair
// LSB first, then publishes sum, carry-out and signed overflow.
module serial_add_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         START,
  input  logic         SUB,
  input  logic         ABORT,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] S,
  output logic         COUT,
  output logic         OVF
);

  localparam int unsigned   CW       = clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t state_q, state_d;

  logic [N-1:0]  sa_q;
  logic [N-1:0]  sb_q;
  logic [N-1:0]  sh_q;
  logic          c_q;
  logic [CW-1:0] cnt_q;
  logic          cin_msb_q;

  logic [N-1:0]  s_q;
  logic          cout_q;
  logic          ovf_q;

  logic          fa_sum;
  logic          fa_carry;
  logic          last_step;

  assign last_step = (cnt_q == CNT_LAST);

  FA u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (c_q),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: START only counts in IDLE, ABORT only outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (last_step) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    BUSY = (state_q != IDLE);
    DONE = (state_q == FIN);
  end

  // Operand load in IDLE and one bit-step per cycle in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q      <= '0;
      sb_q      <= '0;
      sh_q      <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      cin_msb_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with SUB.
            sa_q  <= A;
            sb_q  <= B ^ {N{SUB}};
            c_q   <= SUB;
            cnt_q <= '0;
            sh_q  <= '0;
          end
        end
        RUN: begin
          if (!ABORT) begin
            sa_q <= sa_q >> 1;
            sb_q <= sb_q >> 1;
            sh_q <= {fa_sum, sh_q[N-1:1]};
            c_q  <= fa_carry;
            if (last_step) begin
              // Carry entering the MSB position, needed for signed overflow.
              cin_msb_q <= c_q;
            end else begin
              // Holding at N-1 keeps power-of-two widths from wrapping to 0.
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers: updated only when FIN completes without ABORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if ((state_q == FIN) && !ABORT) begin
      s_q    <= sh_q;
      cout_q <= c_q;
      ovf_q  <= c_q ^ cin_msb_q;
    end
  end

  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with N=8 and a result scoreboard.
module tb_serial_add_ctrl;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         START = 1'b0;
  logic         SUB = 1'b0;
  logic         ABORT = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] S;
  logic         COUT;
  logic         OVF;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .START (START),
    .SUB   (SUB),
    .ABORT (ABORT),
    .A     (A),
    .B     (B),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .COUT  (COUT),
    .OVF   (OVF)
  );

  // Reference arithmetic written from integer semantics, not the serial algorithm.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    exp_t     e;
    logic [N:0] full;
    if (!sub) begin
      full   = {1'b0, a} + {1'b0, b};
      e.s    = full[N-1:0];
      e.cout = full[N];
      e.ovf  = (a[N-1] == b[N-1]) && (e.s[N-1] != a[N-1]);
    end else begin
      e.s    = a - b;
      e.cout = (a >= b);
      e.ovf  = (a[N-1] != b[N-1]) && (e.s[N-1] != a[N-1]);
    end
    return e;
  endfunction

  // Drive one START pulse from a negedge; returns at the negedge after acceptance.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                          input bit push);
    A     = a;
    B     = b;
    SUB   = sub;
    START = 1'b1;
    if (push) sb.push_back(model(a, b, sub));
    @(negedge clk);
    START = 1'b0;
  endtask

  // Bounded wait for DONE; lat counts negedges from the acceptance point.
  task automatic wait_done(output int lat);
    lat = 0;
    while (DONE !== 1'b1 && lat < 4 * N) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({BUSY, DONE, S, COUT, OVF} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               BUSY, DONE, S, COUT, OVF);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({BUSY, DONE, S, COUT, OVF} !== '0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               BUSY, DONE, S, COUT, OVF);
    end
  endtask

  task automatic test_add_sub();
    logic [N-1:0] ta[5] = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80};
    logic [N-1:0] tb[5] = '{8'h3C, 8'h01, 8'h01, 8'h20, 8'h01};
    logic         ts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      int           lat;
      logic [N-1:0] prev_s;
      exp_t         e;
      prev_s = S;
      start_op(ta[i], tb[i], ts[i], 1'b1);
      checks++;
      if (BUSY !== 1'b1) begin
        errors++;
        $display("FAIL arith_busy[%0d]: got %b expected 1", i, BUSY);
      end
      wait_done(lat);
      checks++;
      if (lat != N) begin
        errors++;
        $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, N);
      end
      checks++;
      if (S !== prev_s) begin
        errors++;
        $display("FAIL arith_s_early[%0d]: got %h expected %h", i, S, prev_s);
      end
      @(negedge clk);
      checks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0) begin
        errors++;
        $display("FAIL arith_idle[%0d]: got busy=%b done=%b expected 0 0", i, BUSY, DONE);
      end
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL arith_sb_empty[%0d]: got 0 entries expected 1", i);
      end else begin
        e = sb.pop_front();
        if ({S, COUT, OVF} !== {e.s, e.cout, e.ovf}) begin
          errors++;
          $display("FAIL arith_result[%0d]: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                   i, S, COUT, OVF, e.s, e.cout, e.ovf);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    int   done_at;
    int   ndone;
    exp_t e;
    done_at = -1;
    ndone   = 0;
    start_op(8'h21, 8'h13, 1'b0, 1'b1);
    for (int i = 1; i <= N + 1; i++) begin
      @(negedge clk);
      if (DONE === 1'b1) begin
        done_at = i;
        ndone++;
      end
      if (i == 1 || i == 8) begin
        A     = 8'hE7;
        B     = 8'h99;
        SUB   = 1'b1;
        START = 1'b1;
      end else begin
        START = 1'b0;
      end
    end
    checks++;
    if (ndone != 1 || done_at != N) begin
      errors++;
      $display("FAIL ignore_done: got %0d pulses at %0d expected 1 at %0d", ndone, done_at, N);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL ignore_sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if ({S, COUT, OVF} !== {e.s, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL ignore_result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                 S, COUT, OVF, e.s, e.cout, e.ovf);
      end
    end
    @(negedge clk);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_queue: got busy=%b expected 0", BUSY);
    end
  endtask

  task automatic test_back_to_back();
    int           ndone;
    exp_t         e;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    ndone = 0;
    for (int t = 0; t <= 30; t++) begin
      if (t > 0) @(negedge clk);
      if (DONE === 1'b1) begin
        checks++;
        if (t != 9 + 10 * ndone) begin
          errors++;
          $display("FAIL b2b_done_time: got %0d expected %0d", t, 9 + 10 * ndone);
        end
        ndone++;
      end
      if (t == 10 || t == 20 || t == 30) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_sb_empty: got 0 entries expected 1 at t=%0d", t);
        end else begin
          e = sb.pop_front();
          if ({S, COUT, OVF} !== {e.s, e.cout, e.ovf}) begin
            errors++;
            $display("FAIL b2b_result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                     S, COUT, OVF, e.s, e.cout, e.ovf);
          end
        end
      end
      if (t % 10 == 0 && t < 30) begin
        a     = N'($urandom);
        b     = N'($urandom);
        s     = 1'($urandom);
        A     = a;
        B     = b;
        SUB   = s;
        START = 1'b1;
        sb.push_back(model(a, b, s));
      end else if (t == 30) begin
        START = 1'b0;
      end else begin
        A   = N'($urandom);
        B   = N'($urandom);
        SUB = 1'($urandom);
      end
    end
    checks++;
    if (ndone != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 3", ndone);
    end
  endtask

  task automatic test_abort();
    int   lat;
    int   ndone;
    exp_t e;
    start_op(8'h11, 8'h22, 1'b0, 1'b1);
    wait_done(lat);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL abort_base_sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if ({S, COUT, OVF} !== {e.s, e.cout, e.ovf} || S !== 8'h33) begin
        errors++;
        $display("FAIL abort_base: got s=%h cout=%b ovf=%b expected s=33 cout=0 ovf=0",
                 S, COUT, OVF);
      end
    end
    // Abort at RUN cycle 4.
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL abort_run_busy: got %b expected 0", BUSY);
    end
    ndone = 0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (DONE === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || {S, COUT, OVF} !== {8'h33, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_run_result: got dones=%0d s=%h cout=%b ovf=%b expected 0 33 0 0",
               ndone, S, COUT, OVF);
    end
    // Abort while in FIN.
    start_op(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL abort_fin_latency: got %0d expected %0d", lat, N);
    end
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || {S, COUT, OVF} !== {8'h33, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_fin_result: got busy=%b s=%h cout=%b ovf=%b expected 0 33 0 0",
               BUSY, S, COUT, OVF);
    end
    @(negedge clk);
    checks++;
    if (DONE !== 1'b0 || S !== 8'h33) begin
      errors++;
      $display("FAIL abort_fin_after: got done=%b s=%h expected 0 33", DONE, S);
    end
    // START and ABORT together in IDLE: the start is taken.
    ABORT = 1'b1;
    start_op(8'hC0, 8'h81, 1'b0, 1'b1);
    ABORT = 1'b0;
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL start_wins_busy: got %b expected 1", BUSY);
    end
    wait_done(lat);
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL start_wins_sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if ({S, COUT, OVF} !== {e.s, e.cout, e.ovf}) begin
        errors++;
        $display("FAIL start_wins_result: got s=%h cout=%b ovf=%b expected s=%h cout=%b ovf=%b",
                 S, COUT, OVF, e.s, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_async_reset();
    int   lat;
    exp_t e;
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, S, COUT, OVF} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               BUSY, DONE, S, COUT, OVF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({BUSY, DONE, S, COUT, OVF} !== '0) begin
      errors++;
      $display("FAIL async_reset_release: got busy=%b done=%b s=%h cout=%b ovf=%b expected all 0",
               BUSY, DONE, S, COUT, OVF);
    end
    start_op(8'h03, 8'h04, 1'b0, 1'b1);
    wait_done(lat);
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL post_reset_latency: got %0d expected %0d", lat, N);
    end
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL post_reset_sb_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if ({S, COUT, OVF} !== {e.s, e.cout, e.ovf} || S !== 8'h07) begin
        errors++;
        $display("FAIL post_reset_result: got s=%h cout=%b ovf=%b expected s=07 cout=0 ovf=0",
                 S, COUT, OVF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
